// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg
// Shared constants and types for the invader alive-grid slice.
//   COLS/ROWS      : formation size in cells
//   CELL_W/CELL_H  : cell pitch in pixels
//   SPR_W/SPR_H    : sprite footprint anchored at each cell's top-left corner
//   hit_state_t    : states of the bullet-hit query FSM
//   alive_map_t    : ROWS x COLS alive bitmap, indexed [row][col]
// ---------------------------------------------------------------------------
package enemy_pkg;

    localparam int COLS   = 11;
    localparam int ROWS   = 5;
    localparam int CELL_W = 44;
    localparam int CELL_H = 28;
    localparam int SPR_W  = 32;
    localparam int SPR_H  = 16;

    localparam int NUM_ENEMIES = ROWS * COLS;
    localparam int GRID_W      = COLS * CELL_W;
    localparam int GRID_H      = ROWS * CELL_H;

    typedef enum logic [2:0] {
        IDLE,
        DIV_X,
        DIV_Y,
        CHECK,
        RESP
    } hit_state_t;

    typedef logic [ROWS-1:0][COLS-1:0] alive_map_t;

endpackage

// File: rtl/enemy_span_div.sv
// ---------------------------------------------------------------------------
// enemy_span_div
// Iterative subtract-and-count divider. One subtraction per clock until the
// remainder drops below the divisor; done is high for the cycle in which the
// quotient and remainder are final. A start pulse always reloads, even while
// a previous division is still running.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load dividend/divisor and begin
//   dividend  : value to divide (DW bits)
//   divisor   : cell pitch (VW bits), captured on start
//   done      : result valid this cycle
//   quotient  : number of whole divisors removed (QW bits)
//   remainder : what is left, always below the divisor (VW bits)
// ---------------------------------------------------------------------------
module enemy_span_div #(
    parameter int DW = 10,
    parameter int VW = 6,
    parameter int QW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient,
    output logic [VW-1:0] remainder
);

    logic [DW-1:0] rem;
    logic [VW-1:0] div_q;
    logic [QW-1:0] quo;
    logic          busy;
    logic [DW-1:0] div_ext;

    assign div_ext   = {{(DW-VW){1'b0}}, div_q};
    assign done      = busy && (rem < div_ext);
    assign quotient  = quo;
    assign remainder = rem[VW-1:0];

    // Walk the remainder down one pitch per cycle; stop once it fits in a cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            div_q <= '0;
            quo   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            rem   <= dividend;
            div_q <= divisor;
            quo   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            if (rem < div_ext) begin
                busy <= 1'b0;
            end else begin
                rem <= rem - div_ext;
                quo <= quo + 1'b1;
            end
        end
    end

endmodule

// File: rtl/enemy_alive_grid.sv
// ---------------------------------------------------------------------------
// enemy_alive_grid
// Alive/dead bitmap for the invader formation. Answers bullet-hit queries
// against the moving formation origin, drives the per-pixel enemy_on and
// sprite offsets, and reports which columns still hold live enemies.
//   Clk, Reset          : 50 MHz clock, asynchronous active-high reset
//   new_wave            : one-cycle pulse, refills the whole grid
//   origin_x/origin_y   : formation top-left corner
//   DrawX/DrawY         : current pixel; enemy_on/spr_x/spr_y follow 1 cycle later
//   hit_req/hit_x/hit_y : bullet query, held until hit_ack
//   hit_ack/hit_valid   : one-cycle answer, hit_valid=1 when an enemy died
//   hit_row             : row of the destroyed enemy
//   alive_count/all_dead: live enemy count and its zero flag
//   left_col/right_col  : outermost columns still holding a live enemy
// ---------------------------------------------------------------------------
module enemy_alive_grid
    import enemy_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       new_wave,
    input  logic [9:0] origin_x,
    input  logic [9:0] origin_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       hit_req,
    input  logic [9:0] hit_x,
    input  logic [9:0] hit_y,
    output logic       hit_ack,
    output logic       hit_valid,
    output logic [2:0] hit_row,
    output logic       enemy_on,
    output logic [4:0] spr_x,
    output logic [3:0] spr_y,
    output logic [5:0] alive_count,
    output logic       all_dead,
    output logic [3:0] left_col,
    output logic [3:0] right_col
);

    alive_map_t  alive;
    hit_state_t  state;
    hit_state_t  next_state;
    logic        post_resp;

    logic [10:0] hit_dx;
    logic [10:0] hit_dy;
    logic        hit_in_bounds;
    logic        accept_req;
    logic [9:0]  dy_lat;
    logic [3:0]  col_q;
    logic [2:0]  row_q;
    logic [5:0]  rem_x;
    logic [5:0]  rem_y;
    logic        cell_hit;

    logic        div_start;
    logic [9:0]  div_dividend;
    logic [5:0]  div_divisor;
    logic        div_done;
    logic [3:0]  div_quotient;
    logic [5:0]  div_remainder;

    logic [10:0] px_dx;
    logic [10:0] px_dy;
    logic        px_in;
    logic [3:0]  px_col;
    logic [2:0]  px_row;
    logic [9:0]  px_offx;
    logic [9:0]  px_offy;
    logic        px_on;

    logic [COLS-1:0] col_alive;
    logic [3:0]      first_col;
    logic [3:0]      last_col;

    // The top bit of each 11-bit difference is the sign: set means the point
    // lies left of / above the formation.
    assign hit_dx = {1'b0, hit_x} - {1'b0, origin_x};
    assign hit_dy = {1'b0, hit_y} - {1'b0, origin_y};
    assign hit_in_bounds = !hit_dx[10] && !hit_dy[10] &&
                           (hit_dx[9:0] < 10'(GRID_W)) &&
                           (hit_dy[9:0] < 10'(GRID_H));

    // The cycle after RESP is skipped so a request still held from the answered
    // query is not taken as a new one.
    assign accept_req = (state == IDLE) && hit_req && !post_resp;

    assign cell_hit = alive[row_q][col_q] &&
                      (rem_x < 6'(SPR_W)) && (rem_y < 6'(SPR_H));

    assign all_dead = (alive_count == 6'd0);

    enemy_span_div #(
        .DW(10),
        .VW(6),
        .QW(4)
    ) u_div (
        .clk       (Clk),
        .rst       (Reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // Hit FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Hit FSM next state. A refill abandons whatever query is in flight.
    always_comb begin
        next_state = state;
        if (new_wave) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept_req) next_state = hit_in_bounds ? DIV_X : RESP;
                DIV_X:   if (div_done) next_state = DIV_Y;
                DIV_Y:   if (div_done) next_state = CHECK;
                CHECK:   next_state = RESP;
                RESP:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Hit FSM outputs. The single divider runs x first, then is restarted on
    // the latched y offset the same cycle the x result is captured.
    always_comb begin
        hit_ack      = 1'b0;
        div_start    = 1'b0;
        div_dividend = hit_dx[9:0];
        div_divisor  = 6'(CELL_W);
        case (state)
            IDLE: begin
                div_start = accept_req && hit_in_bounds && !new_wave;
            end
            DIV_X: begin
                div_start    = div_done && !new_wave;
                div_dividend = dy_lat;
                div_divisor  = 6'(CELL_H);
            end
            RESP: begin
                hit_ack = 1'b1;
            end
            default: ;
        endcase
    end

    // Query datapath: offsets are frozen on acceptance so origin motion during
    // the query cannot disturb it; cell coordinates are captured from the divider.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            post_resp <= 1'b0;
            dy_lat    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            rem_x     <= '0;
            rem_y     <= '0;
            hit_valid <= 1'b0;
            hit_row   <= '0;
        end else begin
            post_resp <= (state == RESP);
            if (accept_req) begin
                dy_lat    <= hit_dy[9:0];
                hit_valid <= 1'b0;
            end
            if ((state == DIV_X) && div_done) begin
                col_q <= div_quotient;
                rem_x <= div_remainder;
            end
            if ((state == DIV_Y) && div_done) begin
                row_q <= 3'(div_quotient);
                rem_y <= div_remainder;
            end
            if (state == CHECK) begin
                hit_valid <= cell_hit;
                if (cell_hit) hit_row <= row_q;
            end
        end
    end

    // Alive bitmap and count. A refill outranks a same-cycle kill, and a kill
    // only ever lands on a live bit so the count cannot wrap.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            alive       <= '1;
            alive_count <= 6'(NUM_ENEMIES);
        end else if (new_wave) begin
            alive       <= '1;
            alive_count <= 6'(NUM_ENEMIES);
        end else if ((state == CHECK) && cell_hit) begin
            alive[row_q][col_q] <= 1'b0;
            alive_count         <= alive_count - 6'd1;
        end
    end

    // Column occupancy and its outermost set bits; an empty grid reports the
    // full span so the mover keeps its normal turn points.
    always_comb begin
        col_alive = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                col_alive[c] = col_alive[c] | alive[r][c];
            end
        end
        first_col = 4'd0;
        last_col  = 4'(COLS-1);
        for (int c = COLS-1; c >= 0; c--) begin
            if (col_alive[c]) first_col = 4'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_alive[c]) last_col = 4'(c);
        end
    end

    // Registered column extents for the formation mover.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            left_col  <= 4'd0;
            right_col <= 4'(COLS-1);
        end else begin
            left_col  <= first_col;
            right_col <= last_col;
        end
    end

    // Pixel path: locate the cell with a comparator chain over pitch multiples
    // instead of a divider; the last multiple not exceeding the offset wins.
    assign px_dx = {1'b0, DrawX} - {1'b0, origin_x};
    assign px_dy = {1'b0, DrawY} - {1'b0, origin_y};
    assign px_in = !px_dx[10] && !px_dy[10] &&
                   (px_dx[9:0] < 10'(GRID_W)) &&
                   (px_dy[9:0] < 10'(GRID_H));

    always_comb begin
        px_col  = 4'd0;
        px_offx = px_dx[9:0];
        for (int c = 1; c < COLS; c++) begin
            if (px_dx[9:0] >= 10'(c * CELL_W)) begin
                px_col  = 4'(c);
                px_offx = px_dx[9:0] - 10'(c * CELL_W);
            end
        end
        px_row  = 3'd0;
        px_offy = px_dy[9:0];
        for (int r = 1; r < ROWS; r++) begin
            if (px_dy[9:0] >= 10'(r * CELL_H)) begin
                px_row  = 3'(r);
                px_offy = px_dy[9:0] - 10'(r * CELL_H);
            end
        end
        px_on = px_in && alive[px_row][px_col] &&
                (px_offx < 10'(SPR_W)) && (px_offy < 10'(SPR_H));
    end

    // Pixel outputs, one cycle behind DrawX/DrawY; offsets are zero off-sprite.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            enemy_on <= 1'b0;
            spr_x    <= '0;
            spr_y    <= '0;
        end else begin
            enemy_on <= px_on;
            spr_x    <= px_on ? px_offx[4:0] : 5'd0;
            spr_y    <= px_on ? px_offy[3:0] : 4'd0;
        end
    end

endmodule

// File: tb/tb_enemy_alive_grid.sv
// ---------------------------------------------------------------------------
// tb_enemy_alive_grid
// Self-checking bench for enemy_alive_grid. A plain array model of the grid
// predicts hit results, pixel outputs, counts and column extents using
// ordinary division and modulo on the pixel offsets.
// ---------------------------------------------------------------------------
module tb_enemy_alive_grid;
    import enemy_pkg::*;

    localparam int HIT_BUDGET = COLS + ROWS + 3;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       new_wave;
    logic [9:0] origin_x;
    logic [9:0] origin_y;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hit_req;
    logic [9:0] hit_x;
    logic [9:0] hit_y;
    logic       hit_ack;
    logic       hit_valid;
    logic [2:0] hit_row;
    logic       enemy_on;
    logic [4:0] spr_x;
    logic [3:0] spr_y;
    logic [5:0] alive_count;
    logic       all_dead;
    logic [3:0] left_col;
    logic [3:0] right_col;

    int vectors     = 0;
    int miscompares = 0;

    bit model_alive [ROWS][COLS];
    int model_count;

    enemy_alive_grid dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .new_wave    (new_wave),
        .origin_x    (origin_x),
        .origin_y    (origin_y),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .hit_req     (hit_req),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .hit_ack     (hit_ack),
        .hit_valid   (hit_valid),
        .hit_row     (hit_row),
        .enemy_on    (enemy_on),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .alive_count (alive_count),
        .all_dead    (all_dead),
        .left_col    (left_col),
        .right_col   (right_col)
    );

    // Free-running clock; inputs change and outputs are sampled on the falling edge.
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void modelRefill();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model_alive[r][c] = 1'b1;
        model_count = NUM_ENEMIES;
    endfunction

    function automatic void modelExtents(output int lo, output int hi);
        bit found;
        bit live;
        found = 1'b0;
        lo = 0;
        hi = COLS - 1;
        for (int c = 0; c < COLS; c++) begin
            live = 1'b0;
            for (int r = 0; r < ROWS; r++)
                if (model_alive[r][c]) live = 1'b1;
            if (live) begin
                if (!found) lo = c;
                hi = c;
                found = 1'b1;
            end
        end
    endfunction

    function automatic void modelHit(input int ox, input int oy, input int hx, input int hy,
                                     output bit valid, output int row, output int col);
        int dx;
        int dy;
        dx = hx - ox;
        dy = hy - oy;
        valid = 1'b0;
        row = 0;
        col = 0;
        if (dx >= 0 && dx < GRID_W && dy >= 0 && dy < GRID_H) begin
            col = dx / CELL_W;
            row = dy / CELL_H;
            valid = model_alive[row][col] && ((dx % CELL_W) < SPR_W) && ((dy % CELL_H) < SPR_H);
        end
    endfunction

    task automatic checkStatus();
        int lo;
        int hi;
        modelExtents(lo, hi);
        checkOutput("alive_count", int'(alive_count), model_count);
        checkOutput("all_dead", int'(all_dead), int'(model_count == 0));
        checkOutput("left_col", int'(left_col), lo);
        checkOutput("right_col", int'(right_col), hi);
    endtask

    // Waits for the answer to a raised request, checks it, and keeps hit_req
    // high one extra cycle to make sure the answered request is not served twice.
    task automatic finishQuery(input int budget, input bit exp_valid, input int exp_row,
                               input int exp_col, input bit scramble);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            @(negedge Clk);
            n++;
            if (hit_ack) got = 1'b1;
            else if (scramble && n == 1) begin
                origin_x = 10'($urandom_range(0, 1023));
                origin_y = 10'($urandom_range(0, 1023));
            end
        end
        checkOutput("ack_in_budget", int'(got), 1);
        if (got) begin
            checkOutput("hit_valid", int'(hit_valid), int'(exp_valid));
            if (exp_valid) begin
                checkOutput("hit_row", int'(hit_row), exp_row);
                model_alive[exp_row][exp_col] = 1'b0;
                model_count--;
            end
        end
        @(negedge Clk);
        checkOutput("ack_one_cycle", int'(hit_ack), 0);
        @(negedge Clk);
        checkOutput("no_reservice", int'(hit_ack), 0);
        hit_req = 1'b0;
        checkStatus();
        @(negedge Clk);
    endtask

    task automatic applyStimulus(input int hx, input int hy, input int budget, input bit scramble);
        bit v;
        int r;
        int c;
        modelHit(int'(origin_x), int'(origin_y), hx, hy, v, r, c);
        hit_x = 10'(hx);
        hit_y = 10'(hy);
        hit_req = 1'b1;
        finishQuery(budget, v, r, c, scramble);
    endtask

    task automatic probePixel(input int ox, input int oy, input int px, input int py);
        int dx;
        int dy;
        int exp_on;
        int exp_sx;
        int exp_sy;
        dx = px - ox;
        dy = py - oy;
        exp_on = 0;
        exp_sx = 0;
        exp_sy = 0;
        if (dx >= 0 && dx < GRID_W && dy >= 0 && dy < GRID_H) begin
            if (model_alive[dy / CELL_H][dx / CELL_W] &&
                (dx % CELL_W) < SPR_W && (dy % CELL_H) < SPR_H) begin
                exp_on = 1;
                exp_sx = dx % CELL_W;
                exp_sy = dy % CELL_H;
            end
        end
        origin_x = 10'(ox);
        origin_y = 10'(oy);
        DrawX = 10'(px);
        DrawY = 10'(py);
        @(negedge Clk);
        checkOutput("enemy_on", int'(enemy_on), exp_on);
        checkOutput("spr_x", int'(spr_x), exp_sx);
        checkOutput("spr_y", int'(spr_y), exp_sy);
    endtask

    // Last-resort guard so the run always ends even if a wait is mis-bounded.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    // Main sequence: reset, directed corner cases, randomized traffic, abort, wipe-out.
    initial begin
        int hx;
        int hy;
        int ox;
        int oy;
        bit v;
        int r;
        int c;

        Reset = 1'b1;
        new_wave = 1'b0;
        origin_x = '0;
        origin_y = '0;
        DrawX = '0;
        DrawY = '0;
        hit_req = 1'b0;
        hit_x = '0;
        hit_y = '0;
        modelRefill();
        repeat (3) @(negedge Clk);
        checkOutput("reset_enemy_on", int'(enemy_on), 0);
        checkOutput("reset_hit_ack", int'(hit_ack), 0);
        checkOutput("reset_hit_valid", int'(hit_valid), 0);
        checkOutput("reset_hit_row", int'(hit_row), 0);
        checkOutput("reset_spr_x", int'(spr_x), 0);
        checkOutput("reset_spr_y", int'(spr_y), 0);
        checkStatus();
        Reset = 1'b0;
        @(negedge Clk);
        checkStatus();

        probePixel(100, 20, 100, 20);
        probePixel(100, 20, 132, 20);
        probePixel(100, 20, 99, 20);
        probePixel(100, 20, 100 + GRID_W, 20);
        origin_x = '0;
        origin_y = '0;

        applyStimulus(50, 30, HIT_BUDGET, 1'b0);
        applyStimulus(50, 30, HIT_BUDGET, 1'b0);
        applyStimulus(40, 5, HIT_BUDGET, 1'b0);
        applyStimulus(600, 5, 2, 1'b0);
        applyStimulus(483, 139, HIT_BUDGET, 1'b0);

        for (int k = 0; k < ROWS; k++)
            applyStimulus(5, 5 + CELL_H * k, HIT_BUDGET, 1'b0);
        checkOutput("left_after_col0", int'(left_col), 1);

        for (int i = 0; i < 40; i++) begin
            origin_x = 10'($urandom_range(20, 480));
            origin_y = 10'($urandom_range(10, 300));
            hx = int'(origin_x) + int'($urandom_range(0, 520)) - 20;
            hy = int'(origin_y) + int'($urandom_range(0, 160)) - 10;
            applyStimulus(hx, hy, HIT_BUDGET, 1'b1);
            ox = int'($urandom_range(20, 480));
            oy = int'($urandom_range(10, 300));
            probePixel(ox, oy, ox + int'($urandom_range(0, 520)) - 20,
                       oy + int'($urandom_range(0, 160)) - 10);
        end

        origin_x = '0;
        origin_y = '0;
        new_wave = 1'b1;
        @(negedge Clk);
        new_wave = 1'b0;
        modelRefill();
        @(negedge Clk);
        checkStatus();
        for (int k = 1; k < COLS; k++)
            applyStimulus(CELL_W * k + 5, 5, HIT_BUDGET, 1'b0);
        checkOutput("ten_killed", int'(alive_count), NUM_ENEMIES - 10);

        hit_x = 10'(CELL_W * (COLS - 1) + 5);
        hit_y = 10'd5;
        hit_req = 1'b1;
        @(negedge Clk);
        checkOutput("abort_pre_ack", int'(hit_ack), 0);
        new_wave = 1'b1;
        @(negedge Clk);
        new_wave = 1'b0;
        modelRefill();
        checkOutput("abort_refill_count", int'(alive_count), NUM_ENEMIES);
        checkOutput("abort_no_ack", int'(hit_ack), 0);
        modelHit(0, 0, CELL_W * (COLS - 1) + 5, 5, v, r, c);
        finishQuery(HIT_BUDGET, v, r, c, 1'b0);

        for (int rr = 0; rr < ROWS; rr++)
            for (int cc = 0; cc < COLS; cc++)
                applyStimulus(CELL_W * cc + 5, CELL_H * rr + 5, HIT_BUDGET, 1'b0);
        checkOutput("all_dead_final", int'(all_dead), 1);
        checkOutput("left_dead", int'(left_col), 0);
        checkOutput("right_dead", int'(right_col), COLS - 1);
        applyStimulus(50, 30, HIT_BUDGET, 1'b0);
        probePixel(0, 0, 5, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/enemy_alive_grid.md
Name: enemy_alive_grid

Overview:
Downstream of the enemy formation mover. Holds the alive/dead bitmap for the invader formation and resolves bullet-hit queries against the moving formation origin. Drives the per-pixel enemy_on and sprite offsets to the colour mapper. Feeds alive-column extents back to the formation mover, so edge turns track the surviving columns.

Parameters:
COLS, 11, formation columns
ROWS, 5, formation rows
CELL_W, 44, horizontal pitch in pixels
CELL_H, 28, vertical pitch in pixels
SPR_W, 32, sprite width inside a cell, starting at the cell's left edge
SPR_H, 16, sprite height inside a cell, starting at the cell's top edge

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-high reset
new_wave  in  1  one-cycle pulse; refill the grid
origin_x  in  10  formation left edge (L_Edge)
origin_y  in  10  formation top edge (U_Edge)
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
hit_req  in  1  bullet query; held high until hit_ack
hit_x  in  10  bullet x, stable while hit_req is high
hit_y  in  10  bullet y, stable while hit_req is high
hit_ack  out  1  one-cycle response pulse
hit_valid  out  1  qualifies hit_ack: 1 = an enemy was destroyed
hit_row  out  3  row of the destroyed enemy, for score lookup
enemy_on  out  1  pixel lies on a live sprite
spr_x  out  5  x offset inside the sprite
spr_y  out  4  y offset inside the sprite
alive_count  out  6  number of live enemies
all_dead  out  1  alive_count == 0
left_col  out  4  lowest column index with any live enemy
right_col  out  4  highest column index with any live enemy

Behaviour:
- Reset (async) and new_wave both set every alive bit to 1 and alive_count to ROWS*COLS (55).
- Reset also clears hit_ack, hit_valid, hit_row, enemy_on, spr_x and spr_y to 0, sets left_col to 0 and right_col to COLS-1, and puts the FSM in IDLE.
- Pixel path: registered, latency 1 Clk.
  - dx = DrawX - origin_x and dy = DrawY - origin_y, computed 11-bit signed.
  - Negative dx or dy, dx ≥ COLS*CELL_W, or dy ≥ ROWS*CELL_H gives enemy_on=0.
  - Otherwise column and row come from a comparator chain against multiples of CELL_W / CELL_H, with no divider.
  - enemy_on = alive[row][col] && (dx mod CELL_W) < SPR_W && (dy mod CELL_H) < SPR_H.
  - spr_x and spr_y are the in-cell offsets; they are 0 when enemy_on=0.
- Hit FSM states: IDLE, DIV_X, DIV_Y, CHECK, RESP.
  - IDLE: when hit_req=1, latch hit_x - origin_x and hit_y - origin_y. If the point is out of the formation bounds, go straight to RESP with a miss; otherwise go to DIV_X.
  - DIV_X: subtract CELL_W per cycle, incrementing col, until remainder < CELL_W. DIV_Y does the same with CELL_H and row.
  - CHECK: a hit requires alive[row][col]=1, remainder_x < SPR_W and remainder_y < SPR_H. On a hit, clear the bit, decrement alive_count and set hit_row.
  - RESP: hit_ack=1 for exactly one cycle, with hit_valid meaningful. Then IDLE.
  - IDLE ignores hit_req during the cycle right after RESP, so a held request is not re-serviced. The requester must drop hit_req after ack.
- Worst-case latency from hit_req to hit_ack is COLS+ROWS+3 cycles.
- The origin moves only on frame_clk edges. The latched offset is used throughout the query, so an origin change mid-query does not affect it.
- new_wave mid-query aborts the FSM to IDLE with no ack. The still-held hit_req is re-evaluated against the refilled grid.
- new_wave and the CHECK clear in the same cycle: the refill wins and alive_count = 55.
- left_col and right_col are registered from the OR of each column's bits, updated 1 cycle after any bitmap change.
- When all_dead=1, left_col holds 0 and right_col holds COLS-1.
- alive_count never wraps: a clear can only occur on a live bit.

Decomposition:
- Shared package enemy_pkg holds:
  - constants COLS, ROWS, CELL_W, CELL_H, SPR_W, SPR_H;
  - the hit-FSM state enum;
  - the typedef for the ROWS×COLS alive bitmap.
- One sub-module, enemy_span_div: an iterative subtract-and-count divider (start/done, quotient, remainder). It is instantiated once and reused sequentially for x then y.

Test Plan:
- Reset with origin (0,0) → alive_count=55, all_dead=0, left_col=0, right_col=10, enemy_on=0.
- hit_req at (50,30), origin (0,0) → within 19 cycles hit_ack=1, hit_valid=1, hit_row=1, alive_count=54. The same query repeated → hit_valid=0, alive_count stays 54.
- hit_req at (40,5): remainder_x 40 ≥ 32 → hit_valid=0. hit_req at (600,5): out of bounds → ack within 2 cycles, hit_valid=0.
- Kill column 0 with hits at x=5, y=5+28r for r=0..4 → left_col=1. Kill all 55 → all_dead=1, left_col=0, right_col=10.
- Origin (100,20), DrawX=100, DrawY=20 → the next cycle gives enemy_on=1, spr_x=0, spr_y=0. DrawX=132 → enemy_on=0.
- Assert new_wave while the FSM is in DIV_X with 10 enemies dead → alive_count=55 next cycle, no ack for the aborted query, and the held hit_req is then serviced against the full grid.
